// File: rtl/mux_scan_sequencer_if.sv
// Bundle of scan-control and selector signals for mux_scan_sequencer.
//   start  : scan request
//   cont   : continuous-mode request, captured with an accepted start
//   abort  : cancel of a scan in progress
//   q      : selector Q output fed back to the sequencer
//   sel    : select lines SEL2..SEL0
//   ce_n   : selector enable, active-low
//   busy   : scan in progress
//   done   : one-cycle pulse when data has been updated
//   data   : last complete scan byte
// The slave modport is the sequencer; the master modport is whatever drives
// the requests and the selector (the surrounding system or a bench).
interface mux_scan_sequencer_if;
  logic       start;
  logic       cont;
  logic       abort;
  logic       q;
  logic [2:0] sel;
  logic       ce_n;
  logic       busy;
  logic       done;
  logic [7:0] data;

  modport master (
    output start, cont, abort, q,
    input  sel, ce_n, busy, done, data
  );

  modport slave (
    input  start, cont, abort, q,
    output sel, ce_n, busy, done, data
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Closed-loop driver/collector for an external 1-of-8 selector. Walks the
// select lines 0..7, holds each select SETTLE+1 cycles, samples q on the last
// one and publishes the assembled byte with a one-cycle done pulse.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous reset, active-high
//   bus    : mux_scan_sequencer_if.slave (start/cont/abort/q in,
//            sel/ce_n/busy/done/data out)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | selector disabled, waiting for start
// SCAN  | selector enabled, settling/sampling the current select
// DONE  | one cycle; data already holds the new byte, done pulses
module mux_scan_sequencer #(
  parameter int unsigned SETTLE = 1
) (
  input logic                 clk,
  input logic                 reset,
  mux_scan_sequencer_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  logic [1:0] state;
  logic [2:0] sel_q;
  logic [3:0] cnt;
  logic       cont_q;
  logic [7:0] shadow;
  logic [7:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      sel_q  <= 3'd0;
      cnt    <= 4'd0;
      cont_q <= 1'b0;
      shadow <= 8'd0;
      data_q <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state  <= ST_SCAN;
            sel_q  <= 3'd0;
            cnt    <= SETTLE_CNT;
            cont_q <= bus.cont;
          end
        end

        ST_SCAN: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            sel_q  <= 3'd0;
            cnt    <= 4'd0;
            shadow <= 8'd0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            shadow[sel_q] <= bus.q;
            if (sel_q == 3'd7) begin
              // The final bit goes straight into data so the byte appears
              // complete in the DONE cycle.
              data_q <= {bus.q, shadow[6:0]};
              state  <= ST_DONE;
              sel_q  <= 3'd0;
            end else begin
              sel_q <= sel_q + 3'd1;
              cnt   <= SETTLE_CNT;
            end
          end
        end

        ST_DONE: begin
          if (bus.abort) begin
            state  <= ST_IDLE;
            cont_q <= 1'b0;
          end else if (cont_q) begin
            state <= ST_SCAN;
            sel_q <= 3'd0;
            cnt   <= SETTLE_CNT;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          sel_q <= 3'd0;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // sel_q is forced to 0 whenever SCAN is left, so it can drive sel directly.
  assign bus.sel  = sel_q;
  assign bus.ce_n = (state != ST_SCAN);
  assign bus.busy = (state == ST_SCAN);
  assign bus.done = (state == ST_DONE);
  assign bus.data = data_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (SETTLE=0 and SETTLE=1) share
// the request stimulus, each with its own model 8:1 selector. A timestamp
// model predicts per-cycle outputs and pushes expected done events into a
// queue that a separate monitor pops when the DUT pulses done.
module tb_mux_scan_sequencer;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] mux_in = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int S = (g == 0) ? 0 : 1;
    localparam int L = 8 * (S + 1);

    mux_scan_sequencer_if bus ();

    assign bus.start = start;
    assign bus.cont  = cont;
    assign bus.abort = abort;
    assign bus.q     = mux_in[bus.sel];

    mux_scan_sequencer #(.SETTLE(S)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    // Model: a scan starting in cycle s occupies cycles s..s+L-1; bit i is
    // the selector input during cycle s+(i+1)*(S+1)-1; done is cycle s+L.
    int         cyc = 0;
    int         scan_s = -1;
    int         done_c = -1;
    bit         m_cont = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] hist [int];
    exp_t       exp_q [$];

    always @(posedge clk) begin
      logic [7:0] b;
      hist[cyc] = mux_in;
      if (reset) begin
        scan_s = -1;
        done_c = -1;
        m_cont = 1'b0;
        m_data = 8'h00;
        exp_q.delete();
      end else if (scan_s >= 0 && cyc >= scan_s) begin
        if (abort) begin
          scan_s = -1;
        end else if (cyc == scan_s + L - 1) begin
          for (int i = 0; i < 8; i++) begin
            logic [7:0] h;
            h = hist[scan_s + (i + 1) * (S + 1) - 1];
            b[i] = h[i];
          end
          m_data = b;
          exp_q.push_back('{cyc: cyc + 1, data: b});
          done_c = cyc + 1;
          scan_s = -1;
        end
      end else if (done_c == cyc) begin
        if (abort) m_cont = 1'b0;
        else if (m_cont) scan_s = cyc + 1;
      end else if (start) begin
        scan_s = cyc + 1;
        m_cont = cont;
      end
      cyc++;
    end

    always @(negedge clk) begin
      int eb, es;
      eb = (scan_s >= 0 && cyc >= scan_s) ? 1 : 0;
      es = eb ? (cyc - scan_s) / (S + 1) : 0;
      chk($sformatf("s%0d busy", S), int'(bus.busy), eb);
      chk($sformatf("s%0d ce_n", S), int'(bus.ce_n), 1 - eb);
      chk($sformatf("s%0d sel", S), int'(bus.sel), es);
      chk($sformatf("s%0d done", S), int'(bus.done), (done_c == cyc) ? 1 : 0);
      chk($sformatf("s%0d data", S), int'(bus.data), int'(m_data));
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("s%0d unexpected_done", S), 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("s%0d done_cycle", S), cyc, e.cyc);
          chk($sformatf("s%0d done_data", S), int'(bus.data), int'(e.data));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sel1(input logic [2:0] v, input string nm);
    int k = 0;
    while (!(g_dut[1].bus.busy === 1'b1 && g_dut[1].bus.sel === v) && k < 200) begin
      step(1);
      k++;
    end
    chk({"wait ", nm}, (k < 200) ? 1 : 0, 1);
  endtask

  task automatic wait_done1(input string nm);
    int k = 0;
    while (g_dut[1].bus.done !== 1'b1 && k < 200) begin
      step(1);
      k++;
    end
    chk({"wait ", nm}, (k < 200) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while ((g_dut[0].bus.busy !== 1'b0 || g_dut[0].bus.done !== 1'b0 ||
            g_dut[1].bus.busy !== 1'b0 || g_dut[1].bus.done !== 1'b0) && k < 400) begin
      step(1);
      k++;
    end
    chk({"wait ", nm}, (k < 400) ? 1 : 0, 1);
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    step(2);

    // Single shot of 8'hA5
    mux_in = 8'hA5;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_idle("a5");
    step(1);
    chk("a5 data s1", int'(g_dut[1].bus.data), 8'hA5);
    chk("a5 data s0", int'(g_dut[0].bus.data), 8'hA5);

    // Single shot of 8'h3C
    mux_in = 8'h3C;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_idle("3c");
    chk("3c data s0", int'(g_dut[0].bus.data), 8'h3C);

    // Continuous: input changes mid-scan, second scan clean, abort in third
    mux_in = 8'hA5;
    cont = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    cont = 1'b0;
    wait_sel1(3'd2, "cont sel2");
    mux_in = 8'h5A;
    wait_done1("cont done1");
    step(1);
    wait_done1("cont done2");
    step(1);
    wait_sel1(3'd3, "cont sel3");
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    wait_idle("cont abort");
    step(4);
    chk("cont data s1", int'(g_dut[1].bus.data), 8'h5A);

    // Abort on the final-sample edge, data previously 0
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    mux_in = 8'hFF;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_sel1(3'd7, "final sel7");
    step(1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("final abort data s1", int'(g_dut[1].bus.data), 8'h00);
    chk("final abort busy s1", int'(g_dut[1].bus.busy), 0);
    wait_idle("final");

    // Reset mid-scan with start held high
    mux_in = 8'h96;
    start = 1'b1;
    wait_sel1(3'd4, "rst sel4");
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    start = 1'b0;
    step(2);
    chk("rst data s1", int'(g_dut[1].bus.data), 8'h00);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_idle("after rst");

    // start held high, cont=0
    mux_in = 8'hC3;
    start = 1'b1;
    step(60);
    start = 1'b0;
    wait_idle("held start");

    // Randomized
    for (int n = 0; n < 600; n++) begin
      start = ($urandom_range(0, 3) == 0);
      cont = $urandom_range(0, 1);
      abort = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) mux_in = 8'($urandom);
      step(1);
    end
    start = 1'b0;
    cont = 1'b0;
    abort = 1'b1;
    reset = 1'b0;
    step(1);
    abort = 1'b0;
    wait_idle("random");
    step(2);

    chk("pending s0", g_dut[0].exp_q.size(), 0);
    chk("pending s1", g_dut[1].exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
